// File: rtl/rom_read_arbiter.sv
// ============================================================================
// rom_read_arbiter: shares a single-read-port ROM between two requesters with
// round-robin arbitration, a two-cycle slot per access, and fault flagging.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rom_read_arbiter #(
    parameter int ROM_WORDS_LOG2 = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    output logic [31:0] m0_rdata,
    output logic        m0_rvalid,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    output logic [31:0] m1_rdata,
    output logic        m1_rvalid,
    output logic        m1_err,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    output logic        busy
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    state_t      r_state;
    logic        r_gnt;
    logic        r_last_grant;
    logic        r_fault;

    logic        w_any_req;
    logic        w_sel;
    logic [31:0] w_addr;
    logic        w_fault;

    // On a tie the port not served last wins; otherwise the lone requester.
    assign w_any_req = m0_req | m1_req;
    assign w_sel     = (m0_req & m1_req) ? ~r_last_grant : m1_req;
    assign w_addr    = w_sel ? m1_addr : m0_addr;
    assign w_fault   = (|w_addr[1:0]) | (|w_addr[31:ROM_WORDS_LOG2+2]);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_gnt        <= 1'b0;
            r_last_grant <= 1'b1;
            r_fault      <= 1'b0;
            rom_addr     <= '0;
            m0_rdata     <= '0;
            m0_rvalid    <= 1'b0;
            m0_err       <= 1'b0;
            m1_rdata     <= '0;
            m1_rvalid    <= 1'b0;
            m1_err       <= 1'b0;
            busy         <= 1'b0;
        end else begin
            m0_rvalid <= 1'b0;
            m0_err    <= 1'b0;
            m1_rvalid <= 1'b0;
            m1_err    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        rom_addr <= w_addr;
                        r_gnt    <= w_sel;
                        r_fault  <= w_fault;
                        busy     <= 1'b1;
                        r_state  <= READ;
                    end
                end
                READ: begin
                    // rom_data has settled for rom_addr; a faulted slot returns zero.
                    if (r_gnt) begin
                        m1_rdata  <= r_fault ? 32'h0 : rom_data;
                        m1_rvalid <= 1'b1;
                        m1_err    <= r_fault;
                    end else begin
                        m0_rdata  <= r_fault ? 32'h0 : rom_data;
                        m0_rvalid <= 1'b1;
                        m0_err    <= r_fault;
                    end
                    r_last_grant <= r_gnt;
                    busy         <= 1'b0;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rom_read_arbiter.sv
// ============================================================================
// tb_rom_read_arbiter: directed test of rom_read_arbiter against a ROM model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rom_read_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        m0_req = 1'b0;
    logic [31:0] m0_addr = '0;
    logic [31:0] m0_rdata;
    logic        m0_rvalid;
    logic        m0_err;
    logic        m1_req = 1'b0;
    logic [31:0] m1_addr = '0;
    logic [31:0] m1_rdata;
    logic        m1_rvalid;
    logic        m1_err;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_fn(input logic [14:0] w);
        if (w == 15'd3) return 32'h00500213;
        return {w[7:0], 1'b0, w, 8'h5A};
    endfunction

    assign rom_data = rom_fn(rom_addr[16:2]);

    rom_read_arbiter #(.ROM_WORDS_LOG2(15)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .m0_req    (m0_req),
        .m0_addr   (m0_addr),
        .m0_rdata  (m0_rdata),
        .m0_rvalid (m0_rvalid),
        .m0_err    (m0_err),
        .m1_req    (m1_req),
        .m1_addr   (m1_addr),
        .m1_rdata  (m1_rdata),
        .m1_rvalid (m1_rvalid),
        .m1_err    (m1_err),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .busy      (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_m0_rdata"}, m0_rdata, 32'h0);
        chk({tag, "_m1_rdata"}, m1_rdata, 32'h0);
        chk({tag, "_rom_addr"}, rom_addr, 32'h0);
        chk({tag, "_flags"}, {27'h0, m0_rvalid, m0_err, m1_rvalid, m1_err, busy}, 32'h0);
    endtask

    // One isolated access on a port, with its request released on rvalid.
    task automatic single(input bit port, input logic [31:0] addr,
                          input logic [31:0] exp_data, input logic exp_err);
        if (port) begin m1_req = 1'b1; m1_addr = addr; end
        else      begin m0_req = 1'b1; m0_addr = addr; end
        step();
        chk("grant_busy", {31'h0, busy}, 32'h1);
        chk("grant_rom_addr", rom_addr, addr);
        step();
        chk("done_busy", {31'h0, busy}, 32'h0);
        if (port) begin
            chk("m1_rvalid", {31'h0, m1_rvalid}, 32'h1);
            chk("m1_rdata", m1_rdata, exp_data);
            chk("m1_err", {31'h0, m1_err}, {31'h0, exp_err});
            chk("m0_rvalid_quiet", {31'h0, m0_rvalid}, 32'h0);
            m1_req = 1'b0;
        end else begin
            chk("m0_rvalid", {31'h0, m0_rvalid}, 32'h1);
            chk("m0_rdata", m0_rdata, exp_data);
            chk("m0_err", {31'h0, m0_err}, {31'h0, exp_err});
            chk("m1_rvalid_quiet", {31'h0, m1_rvalid}, 32'h0);
            m0_req = 1'b0;
        end
        step();
        chk("pulse_end", {30'h0, m0_rvalid, m1_rvalid}, 32'h0);
        chk("idle_busy", {31'h0, busy}, 32'h0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        do_reset();
        chk_all_zero("reset");

        // Single read on port 0; port 1 must stay untouched.
        single(1'b0, 32'h0000000C, 32'h00500213, 1'b0);
        chk("m1_rdata_unchanged", m1_rdata, 32'h0);

        // Tie from reset: port 0 first, then strict alternation.
        do_reset();
        m0_addr = 32'h0; m1_addr = 32'h4;
        m0_req = 1'b1; m1_req = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            step();
            chk($sformatf("tie_m0_rvalid_e%0d", e), {31'h0, m0_rvalid}, {31'h0, (e % 4) == 2});
            chk($sformatf("tie_m1_rvalid_e%0d", e), {31'h0, m1_rvalid}, {31'h0, (e % 4) == 0});
            if ((e % 4) == 2) chk($sformatf("tie_m0_rdata_e%0d", e), m0_rdata, rom_fn(15'd0));
            if ((e % 4) == 0) chk($sformatf("tie_m1_rdata_e%0d", e), m1_rdata, rom_fn(15'd1));
        end
        m0_req = 1'b0; m1_req = 1'b0;
        step();

        // Fault cases and the last valid word.
        single(1'b1, 32'h00000006, 32'h0, 1'b1);
        single(1'b0, 32'h00020000, 32'h0, 1'b1);
        single(1'b0, 32'h0001FFFC, rom_fn(15'd32767), 1'b0);

        // Reset during READ aborts the access.
        m0_addr = 32'h8; m0_req = 1'b1;
        step();
        chk("pre_abort_busy", {31'h0, busy}, 32'h1);
        reset_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        m1_addr = 32'h4; m1_req = 1'b1;
        step();
        chk_all_zero("held_reset1");
        step();
        chk_all_zero("held_reset2");
        reset_n = 1'b1;
        step();
        chk("post_reset_grant_addr", rom_addr, 32'h8);
        step();
        chk("post_reset_m0_rvalid", {31'h0, m0_rvalid}, 32'h1);
        chk("post_reset_m0_rdata", m0_rdata, rom_fn(15'd2));
        chk("post_reset_m1_quiet", {31'h0, m1_rvalid}, 32'h0);
        m0_req = 1'b0;
        step();
        chk("post_reset_m1_addr", rom_addr, 32'h4);
        step();
        chk("post_reset_m1_rvalid", {31'h0, m1_rvalid}, 32'h1);
        chk("post_reset_m1_rdata", m1_rdata, rom_fn(15'd1));
        m1_req = 1'b0;
        step();

        // Address change while READ is in progress is ignored for that access.
        m0_addr = 32'h8; m0_req = 1'b1;
        step();
        m0_addr = 32'hC;
        step();
        chk("chg_m0_rvalid", {31'h0, m0_rvalid}, 32'h1);
        chk("chg_m0_rdata", m0_rdata, rom_fn(15'd2));
        step();
        chk("chg_next_addr", rom_addr, 32'hC);
        chk("chg_gap_rvalid", {31'h0, m0_rvalid}, 32'h0);
        step();
        chk("chg_next_rvalid", {31'h0, m0_rvalid}, 32'h1);
        chk("chg_next_rdata", m0_rdata, 32'h00500213);
        m0_req = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
